// File: rtl/bitmanip_pkg.sv
// rtl/bitmanip_pkg.sv - shared types and default widths for the GREV issue controller
//   Purpose : FSM state encoding, default operand/control/tag widths and the
//             result record used by the GREV issue/writeback path.
//   Ports   : none (package).
package bitmanip_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;
  localparam int TAG_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } grev_state_t;

  typedef struct packed {
    logic [XLEN-1:0]  rd;
    logic [TAG_W-1:0] tag;
  } grev_result_t;

endpackage

// File: rtl/grev_result_fifo.sv
// rtl/grev_result_fifo.sv - in-order synchronous result FIFO
//   Purpose : holds completed {rd,tag} results until downstream takes them.
//             Registered head (no fall-through): a push into an empty FIFO
//             is visible on the next cycle.
//   Ports   : clock, resetn (async, active-low, flushes contents)
//             push/push_data    write side, ignored when full
//             pop/pop_data      read side, ignored when empty; pop_data is the head
//             full/empty/count  occupancy status
module grev_result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two or single-entry builds stay correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/grev_issue_ctrl.sv
// rtl/grev_issue_ctrl.sv - issue/writeback controller for the iterative GREV core
//   Purpose : accepts operands over valid/ready, issues one op at a time to the
//             GREV core with a one-cycle start pulse, captures the result in the
//             core_done cycle and returns results in order, with tags, through
//             a small FIFO.
//   Ports   : clock, resetn (async, active-low)
//             in_valid/in_ready, in_rs1, in_rs2, in_tag   operand side
//             core_start, core_rs1, core_rs2              to GREV core
//             core_rd, core_done                          from GREV core
//             out_valid/out_ready, out_rd, out_tag        result side
//   Config  : GREV_ZERO_BYPASS_EN - when defined, an accepted op with in_rs2==0
//             is written straight to the FIFO in the accept cycle without
//             involving the core.
module grev_issue_ctrl #(
  parameter int XLEN       = bitmanip_pkg::XLEN,
  parameter int SHAMT_W    = bitmanip_pkg::SHAMT_W,
  parameter int TAG_W      = bitmanip_pkg::TAG_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [SHAMT_W-1:0] in_rs2,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               core_start,
  output logic [XLEN-1:0]    core_rs1,
  output logic [SHAMT_W-1:0] core_rs2,
  input  logic [XLEN-1:0]    core_rd,
  input  logic               core_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_rd,
  output logic [TAG_W-1:0]   out_tag
);

  import bitmanip_pkg::*;

  localparam int RES_W = XLEN + TAG_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  grev_state_t        state;
  logic [TAG_W-1:0]   tag_q;
  logic               accept;
  logic               bypass;
  logic               fifo_push;
  logic               fifo_pop;
  logic [RES_W-1:0]   fifo_wdata;
  logic [RES_W-1:0]   fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  // Gating with resetn keeps in_ready low while reset is held.
  assign in_ready = resetn && (state == IDLE) && !fifo_full;
  assign accept   = in_valid && in_ready;

`ifdef GREV_ZERO_BYPASS_EN
  assign bypass = accept && (in_rs2 == '0);
`else
  assign bypass = 1'b0;
`endif

  // Bypass can only fire in IDLE and core writes only in WAIT, so the two
  // push sources never collide. core_done outside WAIT is a stale pulse.
  assign fifo_push  = bypass || ((state == WAIT) && core_done);
  assign fifo_wdata = bypass ? {in_rs1, in_tag} : {core_rd, tag_q};
  assign fifo_pop   = out_ready && !fifo_empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      core_start <= 1'b0;
      core_rs1   <= '0;
      core_rs2   <= '0;
      tag_q      <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && !bypass) begin
            core_rs1   <= in_rs1;
            core_rs2   <= in_rs2;
            tag_q      <= in_tag;
            core_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE:   state <= WAIT;
        WAIT:    if (core_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  grev_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_rd    = fifo_rdata[RES_W-1:TAG_W];
  assign out_tag   = fifo_rdata[TAG_W-1:0];

  // The FSM admits a new op only when there is room, so the FIFO can never
  // be pushed while full; occupancy and the empty flag must agree.
  a_fifo_sane: assert property (@(posedge clock) disable iff (!resetn)
    !(fifo_push && fifo_full) && (fifo_empty == (fifo_count == '0)));

endmodule
